// File: rtl/truth_table_scanner_pkg.sv
// Shared types and sizes for the truth-table scanner.
package scanner_pkg;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned ROW_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/truth_table_scanner_if.sv
// Request/stimulus/response bundle between a scan client and the scanner.
interface truth_table_scanner_if;
  import scanner_pkg::*;

  logic            START;
  logic            Y_IN;
  logic [ROWS-1:0] EXPECTED;
  logic            A;
  logic            B;
  logic            C;
  logic            BUSY;
  logic            DONE;
  logic [ROWS-1:0] RESULT;
  logic            MATCH;

  modport master (
    output START, Y_IN, EXPECTED,
    input  A, B, C, BUSY, DONE, RESULT, MATCH
  );

  modport slave (
    input  START, Y_IN, EXPECTED,
    output A, B, C, BUSY, DONE, RESULT, MATCH
  );

endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// Counts the hold time of one input row; expired flags the last settle cycle.
module settle_timer
  import scanner_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  // Settle counter: cleared outside SETTLE, advances while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = enable && (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_scanner.sv
// Walks {A,B,C} through all eight rows, samples Y_IN per row and compares
// the collected truth table against a captured golden vector.
module truth_table_scanner
  import scanner_pkg::*;
#(
  parameter int unsigned    SETTLE_CYCLES    = 2,
  parameter logic [ROWS-1:0] EXPECTED_DEFAULT = 8'h3C
) (
  input logic                  CLK,
  input logic                  N_RESET,
  truth_table_scanner_if.slave bus
);

  state_e          state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROWS-1:0] result_q, result_d;
  logic [ROWS-1:0] exp_q, exp_d;
  logic            match_q, match_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            settle_en;
  logic            expired;

  assign settle_en = (state_q == SETTLE);

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (CLK),
    .rst_n  (N_RESET),
    .clear  (!settle_en),
    .enable (settle_en),
    .expired(expired)
  );

  // State and output registers; reset aborts any scan immediately.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q  <= IDLE;
      row_q    <= '0;
      result_q <= '0;
      exp_q    <= EXPECTED_DEFAULT;
      match_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      result_q <= result_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next state and next register values; row returns to 0 on leaving the scan.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    result_d = result_q;
    exp_d    = exp_q;
    match_d  = match_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          state_d  = SETTLE;
          row_d    = '0;
          result_d = '0;
          match_d  = 1'b0;
          exp_d    = bus.EXPECTED;
          busy_d   = 1'b1;
        end
      end
      SETTLE: begin
        busy_d = 1'b1;
        if (expired) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        result_d[row_q] = bus.Y_IN;
        if (row_q == ROW_W'(ROWS - 1)) begin
          state_d = FINISH;
          row_d   = '0;
          match_d = (result_d == exp_q);
          done_d  = 1'b1;
        end else begin
          state_d = SETTLE;
          row_d   = row_q + ROW_W'(1);
          busy_d  = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.A      = row_q[2];
  assign bus.B      = row_q[1];
  assign bus.C      = row_q[0];
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.RESULT = result_q;
  assign bus.MATCH  = match_q;

endmodule
